// File: rtl/axa_stream_ctrl_pkg.sv
// Shared constants for the AxA streaming controller: word type, FSM encoding,
// operand and result register indices.
package axa_stream_ctrl_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam int N_OPS = 8;
  localparam int N_RES = 4;

  localparam logic [2:0] ST_LOAD  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  // Operands arrive in this order; the load count doubles as the register index.
  localparam logic [2:0] IDX_A11 = 3'd0;
  localparam logic [2:0] IDX_A12 = 3'd1;
  localparam logic [2:0] IDX_A21 = 3'd2;
  localparam logic [2:0] IDX_A22 = 3'd3;
  localparam logic [2:0] IDX_B11 = 3'd4;
  localparam logic [2:0] IDX_B12 = 3'd5;
  localparam logic [2:0] IDX_B21 = 3'd6;
  localparam logic [2:0] IDX_B22 = 3'd7;

  localparam logic [1:0] IDX_C11 = 2'd0;
  localparam logic [1:0] IDX_C12 = 2'd1;
  localparam logic [1:0] IDX_C21 = 2'd2;
  localparam logic [1:0] IDX_C22 = 2'd3;

endpackage

// File: rtl/axa_stream_ctrl_if.sv
// Serial operand-in / result-out stream bundle with valid/ready handshakes.
interface axa_stream_ctrl_if;
  import axa_stream_ctrl_pkg::*;

  word_t in_data;
  logic  in_valid;
  logic  in_ready;
  word_t out_data;
  logic  out_valid;
  logic  out_ready;
  logic  out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/axa_stream_ctrl_timeout_timer.sv
// Cycle counter that flags the last permitted cycle of a bounded wait.
module axa_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axa_stream_ctrl.sv
// Serial-to-parallel front end and parallel-to-serial back end for the 2x2
// matrix adder, driving its Start / C_Ack handshake with bounded waits.
module axa_stream_ctrl
  import axa_stream_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 11
) (
  input  logic  input_Clk,
  input  logic  input_Reset,
  axa_stream_ctrl_if.slave strm,
  output word_t output_A11,
  output word_t output_A12,
  output word_t output_A21,
  output word_t output_A22,
  output word_t output_B11,
  output word_t output_B12,
  output word_t output_B21,
  output word_t output_B22,
  output logic  output_Start,
  output logic  output_C_Ack,
  input  logic  input_Stable,
  input  word_t input_C11,
  input  word_t input_C12,
  input  word_t input_C21,
  input  word_t input_C22,
  output logic  output_Busy,
  output logic  output_Timeout
);

  logic [2:0] state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [1:0] idx_q, idx_d;
  logic       timeout_q, timeout_d;
  word_t      op_q  [N_OPS];
  word_t      op_d  [N_OPS];
  word_t      res_q [N_RES];
  word_t      res_d [N_RES];
  logic       tmr_clr, tmr_en, tmr_expired;

  axa_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_timer (
    .clk    (input_Clk),
    .rst_n  (input_Reset),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    op_d      = op_q;
    res_d     = res_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (strm.in_valid) begin
          op_d[count_q] = strm.in_data;
          if (count_q == IDX_B22) begin
            count_d = '0;
            state_d = ST_START;
          end else begin
            count_d = count_q + 3'd1;
          end
        end
      end
      ST_START: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        // Stable wins even on the expiry cycle.
        if (input_Stable) begin
          state_d = ST_ACK;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          count_d   = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_ACK: begin
        res_d[IDX_C11] = input_C11;
        res_d[IDX_C12] = input_C12;
        res_d[IDX_C21] = input_C21;
        res_d[IDX_C22] = input_C22;
        tmr_clr        = 1'b1;
        state_d        = ST_CLEAR;
      end
      ST_CLEAR: begin
        tmr_en = 1'b1;
        // Results are already captured, so a stuck Stable still lets them drain.
        if (!input_Stable) begin
          state_d = ST_DRAIN;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (strm.out_ready) begin
          if (idx_q == IDX_C22) begin
            idx_d   = '0;
            count_d = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge input_Clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (!input_Reset) begin
      state_q   <= ST_LOAD;
      count_q   <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
      // NOTE: operand/result storage is cleared so no stale word survives a reset.
      op_q      <= '{default: '0};
      res_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
      op_q      <= op_d;
      res_q     <= res_d;
    end
  end

  assign strm.in_ready  = (state_q == ST_LOAD);
  assign strm.out_valid = (state_q == ST_DRAIN);
  assign strm.out_data  = res_q[idx_q];
  assign strm.out_last  = (state_q == ST_DRAIN) && (idx_q == IDX_C22);

  assign output_Start   = (state_q == ST_START);
  assign output_C_Ack   = (state_q == ST_ACK);
  assign output_Busy    = (state_q != ST_LOAD);
  assign output_Timeout = timeout_q;

  assign output_A11 = op_q[IDX_A11];
  assign output_A12 = op_q[IDX_A12];
  assign output_A21 = op_q[IDX_A21];
  assign output_A22 = op_q[IDX_A22];
  assign output_B11 = op_q[IDX_B11];
  assign output_B12 = op_q[IDX_B12];
  assign output_B21 = op_q[IDX_B21];
  assign output_B22 = op_q[IDX_B22];

endmodule

// File: tb/tb_axa_stream_ctrl.sv
// Directed plus randomized bench for axa_stream_ctrl with a behavioural
// adder model and transaction-level expectations.
module tb_axa_stream_ctrl;
  import axa_stream_ctrl_pkg::*;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axa_stream_ctrl_if strm ();

  word_t a11, a12, a21, a22, b11, b12, b21, b22;
  word_t c11, c12, c21, c22;
  logic  start, ack, stable, busy, tmo;

  axa_stream_ctrl #(
    .TIMEOUT_CYCLES(T),
    .TMR_W         (5)
  ) dut (
    .input_Clk     (clk),
    .input_Reset   (rst_n),
    .strm          (strm),
    .output_A11    (a11),
    .output_A12    (a12),
    .output_A21    (a21),
    .output_A22    (a22),
    .output_B11    (b11),
    .output_B12    (b12),
    .output_B21    (b21),
    .output_B22    (b22),
    .output_Start  (start),
    .output_C_Ack  (ack),
    .input_Stable  (stable),
    .input_C11     (c11),
    .input_C12     (c12),
    .input_C21     (c21),
    .input_C22     (c22),
    .output_Busy   (busy),
    .output_Timeout(tmo)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-precision add for positive normal operands with small exponent spread.
  function automatic word_t f32_add(input word_t x, input word_t y);
    logic [7:0]  ea, eb, e;
    logic [23:0] ma, mb;
    logic [64:0] sum;
    logic [24:0] m;
    logic [40:0] rem, half;
    if (x[30:23] >= y[30:23]) begin
      ea = x[30:23]; ma = {1'b1, x[22:0]}; eb = y[30:23]; mb = {1'b1, y[22:0]};
    end else begin
      ea = y[30:23]; ma = {1'b1, y[22:0]}; eb = x[30:23]; mb = {1'b1, x[22:0]};
    end
    sum = ({41'b0, ma} << 40) + (({41'b0, mb} << 40) >> (ea - eb));
    if (sum[64]) begin
      e = ea + 8'd1; m = {1'b0, sum[64:41]}; rem = sum[40:0]; half = 41'h1 << 40;
    end else begin
      e = ea; m = {1'b0, sum[63:40]}; rem = {1'b0, sum[39:0]}; half = 41'h1 << 39;
    end
    if (rem > half || (rem == half && m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 8'd1;
    end
    return {1'b0, e, m[22:0]};
  endfunction

  // Adder model: Stable rises cfg_delay cycles after Start, stays cfg_hold cycles after C_Ack.
  int cfg_delay = 5;
  int cfg_hold  = 0;
  bit cfg_never = 1'b0;
  int phase = 0;
  int n_cnt = 0;
  int m_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase <= 0;
      c11 <= '0; c12 <= '0; c21 <= '0; c22 <= '0;
    end else if (start) begin
      phase <= 1;
      n_cnt <= 1;
      c11 <= f32_add(a11, b11);
      c12 <= f32_add(a12, b12);
      c21 <= f32_add(a21, b21);
      c22 <= f32_add(a22, b22);
    end else if (phase == 1 && ack) begin
      phase <= 2;
      m_cnt <= 0;
    end else if (phase == 1) begin
      n_cnt <= n_cnt + 1;
    end else if (phase == 2) begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign stable = (phase == 1 && !cfg_never && n_cnt >= cfg_delay) ||
                  (phase == 2 && m_cnt < cfg_hold);

  int cyc = 0;
  int start_cnt = 0;
  int ack_cnt = 0;
  int start_cyc = 0;
  int ack_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (ack) begin
      ack_cnt <= ack_cnt + 1;
      ack_cyc <= cyc;
    end
  end

  word_t txn_w [8];
  bit    exp_to = 1'b0;

  task automatic fill_random();
    for (int k = 0; k < 8; k++)
      txn_w[k] = {1'b0, 8'($urandom_range(134, 120)), 23'($urandom)};
  endtask

  task automatic do_load(input int n);
    int i = 0;
    int g = 0;
    bit v;
    while (i < n && g < 400) begin
      @(negedge clk);
      g++;
      v = ($urandom_range(3) != 0);
      strm.in_valid = v;
      strm.in_data  = v ? txn_w[i] : word_t'($urandom);
      if (v && strm.in_ready) i++;
    end
    if (i < n) check("load_bound", i, n);
  endtask

  task automatic run_txn(input int delay, input int hold, input bit never, input int rmode);
    int s0, a0, k, j, g, first_cyc;
    bit saw, first, stalled, rdy, clear_to;
    word_t held_d;
    logic  held_l;
    word_t exp_c [4];
    cfg_delay = delay;
    cfg_hold  = hold;
    cfg_never = never;
    s0 = start_cnt;
    a0 = ack_cnt;
    first_cyc = 0;
    check("ready_before_load", strm.in_ready, 1);
    do_load(8);
    @(negedge clk);
    strm.in_valid = 1'b0;
    check("start_after_8th", start, 1);
    check("busy_at_start", busy, 1);
    check("no_ready_at_start", strm.in_ready, 0);
    check("op_a11", a11, txn_w[0]); check("op_a12", a12, txn_w[1]);
    check("op_a21", a21, txn_w[2]); check("op_a22", a22, txn_w[3]);
    check("op_b11", b11, txn_w[4]); check("op_b12", b12, txn_w[5]);
    check("op_b21", b21, txn_w[6]); check("op_b22", b22, txn_w[7]);
    if (never || delay > T) begin
      k = 0;
      saw = 1'b0;
      do begin
        @(negedge clk);
        k++;
        if (strm.out_valid) saw = 1'b1;
      end while (!strm.in_ready && k < 4 * T);
      exp_to = 1'b1;
      check("wait_abort_latency", k, T + 1);
      check("timeout_flag", tmo, exp_to);
      check("no_out_valid", saw, 0);
      check("start_count", start_cnt - s0, 1);
      check("no_ack", ack_cnt - a0, 0);
    end else begin
      clear_to = (hold >= T);
      if (clear_to) exp_to = 1'b1;
      for (int q = 0; q < 4; q++) exp_c[q] = f32_add(txn_w[q], txn_w[q + 4]);
      j = 0; g = 0; first = 1'b1; stalled = 1'b0; held_d = '0; held_l = 1'b0;
      while (j < 4 && g < 8 * T + 64) begin
        @(negedge clk);
        g++;
        if (strm.out_valid) begin
          if (first) begin
            first = 1'b0;
            first_cyc = cyc;
            check("busy_in_drain", busy, 1);
            check("no_load_in_drain", strm.in_ready, 0);
            check("stable_low_in_drain", stable, 0);
          end
          if (stalled) begin
            check("stall_data_hold", strm.out_data, held_d);
            check("stall_last_hold", strm.out_last, held_l);
          end
          case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = ~strm.out_ready;
            default: rdy = 1'($urandom_range(1));
          endcase
          strm.out_ready = rdy;
          if (rdy) begin
            check($sformatf("out_data_%0d", j), strm.out_data, exp_c[j]);
            check($sformatf("out_last_%0d", j), strm.out_last, (j == 3));
            j++;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held_d  = strm.out_data;
            held_l  = strm.out_last;
          end
        end else begin
          if (stalled) check("stall_valid_hold", strm.out_valid, 1);
          strm.out_ready = (rmode == 2) ? 1'($urandom_range(1)) : 1'b0;
        end
      end
      if (j < 4) check("drain_bound", j, 4);
      @(negedge clk);
      strm.out_ready = 1'b0;
      check("valid_after_drain", strm.out_valid, 0);
      check("ready_after_drain", strm.in_ready, 1);
      check("start_to_ack", ack_cyc - start_cyc, delay + 1);
      check("ack_to_drain", first_cyc - ack_cyc, clear_to ? T + 1 : hold + 2);
      check("start_count", start_cnt - s0, 1);
      check("ack_count", ack_cnt - a0, 1);
      check("timeout_flag", tmo, exp_to);
    end
    check("idle_not_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    strm.in_valid  = 1'b0;
    strm.in_data   = '0;
    strm.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", strm.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_timeout", tmo, 0);
    check("rst_out_valid", strm.out_valid, 0);
    check("rst_out_last", strm.out_last, 0);
    check("rst_start", start, 0);
    check("rst_ack", ack, 0);
    check("rst_a11", a11, 0);
    check("rst_b22", b22, 0);

    for (int k = 0; k < 4; k++) txn_w[k] = 32'h3F80_0000;
    for (int k = 4; k < 8; k++) txn_w[k] = 32'h4000_0000;
    run_txn(5, 0, 1'b0, 0);
    run_txn(5, 0, 1'b0, 1);

    fill_random();
    run_txn(3, 0, 1'b1, 0);
    fill_random();
    run_txn(4, 1, 1'b0, 2);
    fill_random();
    run_txn(2, 3, 1'b0, 1);

    fill_random();
    do_load(5);
    @(negedge clk);
    strm.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_to = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", strm.in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_timeout", tmo, 0);
    check("midrst_a11", a11, 0);
    check("midrst_b11", b11, 0);
    check("midrst_out_valid", strm.out_valid, 0);
    check("midrst_start", start, 0);

    fill_random();
    run_txn(6, 0, 1'b0, 0);
    fill_random();
    run_txn(T, 0, 1'b0, 2);
    fill_random();
    run_txn(1, T, 1'b0, 0);
    fill_random();
    run_txn(T + 1, 0, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_txn(int'($urandom_range(14, 1)), int'($urandom_range(5, 0)), 1'b0,
              int'($urandom_range(2, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
